// File: rtl/data_memory_stage.sv
// MEM stage: data memory with sized loads/stores, LMD latch and branch PC select behind a
// valid/ready handshake with configurable latency. Define MEM_CLEAR_ON_RESET_EN to zero memory on rst.
module data_memory_stage #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic            req_re,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [XLEN-1:0] req_npc,
  input  logic            req_branch,
  input  logic            req_zero,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_lmd,
  output logic [XLEN-1:0] resp_condpc,
  output logic            resp_misalign
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW = 2;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  typedef struct packed {
    logic            we;
    logic            re;
    logic [1:0]      size;
    logic            uns;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] npc;
    logic            branch;
    logic            zero;
  } req_t;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  req_t            req_q, req_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] lmd_q, lmd_d;
  logic [XLEN-1:0] condpc_q, condpc_d;
  logic            mis_q, mis_d;

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0]   idx_c;
  logic [1:0]      off_c;
  logic            misalign_c;
  logic [XLEN-1:0] rd_word_c;
  logic [7:0]      byte_c;
  logic [15:0]     half_c;
  logic [XLEN-1:0] load_c;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wlane_c;
  logic [XLEN-1:0] wr_word_c;
  logic            access_c;
  logic            wr_en_c;
  logic            accept_c;

  // Datapath works on the captured request; four byte lanes per word.
  always_comb begin
    idx_c      = req_q.addr[AW+1:2];
    off_c      = req_q.addr[1:0];
    misalign_c = ((req_q.size == 2'b01) && off_c[0]) || (req_q.size[1] && (off_c != 2'b00));
    rd_word_c  = mem_q[idx_c];
    byte_c     = rd_word_c[{off_c, 3'b000} +: 8];
    half_c     = rd_word_c[{off_c[1], 4'b0000} +: 16];

    unique case (req_q.size)
      2'b00: begin
        load_c  = {{(XLEN-8){~req_q.uns & byte_c[7]}}, byte_c};
        be_c    = 4'b0001 << off_c;
        wlane_c = {(XLEN/8){req_q.wdata[7:0]}};
      end
      2'b01: begin
        load_c  = {{(XLEN-16){~req_q.uns & half_c[15]}}, half_c};
        be_c    = off_c[1] ? 4'b1100 : 4'b0011;
        wlane_c = {(XLEN/16){req_q.wdata[15:0]}};
      end
      default: begin
        load_c  = rd_word_c;
        be_c    = 4'b1111;
        wlane_c = req_q.wdata;
      end
    endcase

    wr_word_c = rd_word_c;
    for (int b = 0; b < 4; b++) begin
      if (be_c[b]) wr_word_c[8*b +: 8] = wlane_c[8*b +: 8];
    end

    access_c = (state_q == StBusy) && (cnt_q == '0);
    wr_en_c  = access_c && req_q.we && !misalign_c;
    accept_c = req_valid && ready_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    valid_d  = 1'b0;
    lmd_d    = lmd_q;
    condpc_d = condpc_q;
    mis_d    = mis_q;

    case (state_q)
      StIdle, StResp: begin
        if (accept_c) begin
          req_d   = '{we: req_we, re: req_re, size: req_size, uns: req_unsigned,
                      addr: req_addr, wdata: req_wdata, npc: req_npc,
                      branch: req_branch, zero: req_zero};
          cnt_d   = CntW'(LATENCY - 1);
          state_d = StBusy;
        end else begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d  = StResp;
          valid_d  = 1'b1;
          // Stores and no-op requests report zero load data.
          lmd_d    = (req_q.re && !req_q.we && !misalign_c) ? load_c : '0;
          mis_d    = misalign_c;
          condpc_d = (req_q.branch && req_q.zero) ? req_q.addr : req_q.npc;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    ready_d = (state_d != StBusy);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      req_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      lmd_q    <= '0;
      condpc_q <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      lmd_q    <= lmd_d;
      condpc_q <= condpc_d;
      mis_q    <= mis_d;
    end
  end

`ifdef MEM_CLEAR_ON_RESET_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) mem_q[i] <= '0;
    end else if (wr_en_c) begin
      mem_q[idx_c] <= wr_word_c;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[idx_c] <= wr_word_c;
  end
`endif

  assign req_ready     = ready_q;
  assign stall         = ~ready_q;
  assign resp_valid    = valid_q;
  assign resp_lmd      = lmd_q;
  assign resp_condpc   = condpc_q;
  assign resp_misalign = mis_q;

endmodule

// File: tb/tb_data_memory_stage.sv
// Bench for data_memory_stage: directed and random requests checked against a byte-level
// memory model; a second instance with LATENCY=3 checks back-to-back response spacing.
module tb_data_memory_stage;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_re, req_unsigned, req_branch, req_zero;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, req_npc;

  logic        rdy1, stall1, rv1, mis1;
  logic [31:0] lmd1, cpc1;
  logic        rdy3, stall3, rv3, mis3;
  logic [31:0] lmd3, cpc3;

  int tests = 0;
  int fails = 0;
  logic [31:0] mem_m [DEPTH];

  always #5 clk = ~clk;

  data_memory_stage #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_re(req_re), .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_npc(req_npc), .req_branch(req_branch), .req_zero(req_zero),
    .stall(stall1), .resp_valid(rv1), .resp_lmd(lmd1), .resp_condpc(cpc1),
    .resp_misalign(mis1)
  );

  data_memory_stage #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3), .req_we(req_we),
    .req_re(req_re), .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_npc(req_npc), .req_branch(req_branch), .req_zero(req_zero),
    .stall(stall3), .resp_valid(rv3), .resp_lmd(lmd3), .resp_condpc(cpc3),
    .resp_misalign(mis3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_rst();
`ifdef MEM_CLEAR_ON_RESET_EN
    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = 32'h0;
`endif
  endtask

  // Reference: byte-addressed access computed with masks and shifts.
  task automatic model_req(input logic we, input logic re, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] npc, input logic br, input logic z,
                           output logic [31:0] lmd, output logic mis, output logic [31:0] cpc);
    int unsigned idx, off, nb;
    logic [63:0] m64;
    logic [31:0] mask, v;
    idx = (addr >> 2) % DEPTH;
    off = addr % 4;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = (addr % nb) != 0;
    cpc = (br && z) ? addr : npc;
    lmd = 32'h0;
    m64 = (64'd1 << (8 * nb)) - 64'd1;
    mask = m64[31:0];
    if (!mis) begin
      if (we) begin
        mem_m[idx] = (mem_m[idx] & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      end else if (re) begin
        v = (mem_m[idx] >> (8 * off)) & mask;
        if (!uns && v[8*nb-1]) v = v | ~mask;
        lmd = v;
      end
    end
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_rst();
  endtask

  // Starts just after a rising edge with dut idle; returns just after the edge following RESP.
  task automatic do_req(input string tag, input logic we, input logic re, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] npc, input logic br, input logic z);
    logic [31:0] elmd, ecpc;
    logic emis;
    int lat, stl;
    model_req(we, re, sz, uns, addr, wd, npc, br, z, elmd, emis, ecpc);
    req_valid = 1'b1; req_we = we; req_re = re; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_npc = npc; req_branch = br; req_zero = z;
    @(negedge clk);
    chk({tag, " ready"}, 32'(rdy1), 32'd1);
    @(posedge clk); #1;
    // Garbage presented while busy must be ignored.
    req_we = 1'($urandom); req_re = 1'($urandom); req_size = 2'($urandom);
    req_addr = $urandom; req_wdata = $urandom; req_npc = $urandom;
    req_branch = 1'($urandom); req_zero = 1'($urandom);
    lat = 0;
    stl = stall1 ? 1 : 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (rv1) begin
        lat = k;
        break;
      end
      if (stall1) stl++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd1);
    chk({tag, " stall cycles"}, 32'(stl), 32'd1);
    chk({tag, " stall in resp"}, 32'(stall1), 32'd0);
    chk({tag, " lmd"}, lmd1, elmd);
    chk({tag, " condpc"}, cpc1, ecpc);
    chk({tag, " misalign"}, 32'(mis1), 32'(emis));
    @(posedge clk); #1;
    chk({tag, " single pulse"}, 32'(rv1), 32'd0);
    chk({tag, " lmd hold"}, lmd1, elmd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, prev1, prev3, n1, n3, st3;
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_re = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; req_npc = '0;
    req_branch = 1'b0; req_zero = 1'b0;
    @(posedge clk); #1;
    chk("reset ready", 32'(rdy1), 32'd1);
    chk("reset stall", 32'(stall1), 32'd0);
    chk("reset resp_valid", 32'(rv1), 32'd0);
    chk("reset lmd", lmd1, 32'd0);
    chk("reset condpc", cpc1, 32'd0);
    chk("reset misalign", 32'(mis1), 32'd0);
    chk("reset ready lat3", 32'(rdy3), 32'd1);
    rst = 1'b0;
    model_rst();

    do_req("sw 4",  1, 0, 2'd2, 0, 32'h4, 32'hABCD1234, 32'h0, 0, 0);
    do_req("lw 4",  0, 1, 2'd2, 0, 32'h4, 32'h0, 32'h0, 0, 0);
    chk("lw 4 value", lmd1, 32'hABCD1234);
    do_req("sw 8",  1, 0, 2'd2, 0, 32'h8, 32'h87654321, 32'h0, 0, 0);
    do_req("sb 9",  1, 0, 2'd0, 0, 32'h9, 32'h00000080, 32'h0, 0, 0);
    do_req("lb 9",  0, 1, 2'd0, 0, 32'h9, 32'h0, 32'h0, 0, 0);
    chk("lb 9 value", lmd1, 32'hFFFFFF80);
    do_req("lbu 9", 0, 1, 2'd0, 1, 32'h9, 32'h0, 32'h0, 0, 0);
    chk("lbu 9 value", lmd1, 32'h00000080);
    do_req("lw 8",  0, 1, 2'd2, 0, 32'h8, 32'h0, 32'h0, 0, 0);
    chk("lw 8 value", lmd1, 32'h87658021);
    do_req("lh 6",  0, 1, 2'd1, 0, 32'h6, 32'h0, 32'h0, 0, 0);
    do_req("lh 7",  0, 1, 2'd1, 0, 32'h7, 32'h0, 32'h0, 0, 0);
    chk("lh 7 misalign", 32'(mis1), 32'd1);
    do_req("lw 5",  0, 1, 2'd2, 0, 32'h5, 32'h0, 32'h0, 0, 0);
    chk("lw 5 misalign", 32'(mis1), 32'd1);
    do_req("sw 5",  1, 0, 2'd2, 0, 32'h5, 32'h55555555, 32'h0, 0, 0);
    do_req("lw 4 after sw 5", 0, 1, 2'd2, 0, 32'h4, 32'h0, 32'h0, 0, 0);
    chk("sw 5 no write", lmd1, 32'hABCD1234);
    do_req("br taken", 0, 0, 2'd2, 0, 32'h100, 32'h0, 32'h200, 1, 1);
    chk("br taken value", cpc1, 32'h100);
    do_req("br zero0", 0, 0, 2'd2, 0, 32'h100, 32'h0, 32'h200, 1, 0);
    do_req("br nobr",  0, 0, 2'd2, 0, 32'h100, 32'h0, 32'h200, 0, 1);
    chk("br nobr value", cpc1, 32'h200);

    for (int w = 0; w < 16; w++)
      do_req("init", 1, 0, 2'd2, 0, 32'(w * 4), $urandom, $urandom, 0, 0);
    for (int i = 0; i < 40; i++) begin
      a = ($urandom & 32'hFFFF_F000) | 32'(($urandom % 16) * 4) | 32'($urandom % 4);
      do_req("rand", 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
             $urandom, 1'($urandom), 1'($urandom));
    end

    // Reset in the middle of a store: request dropped, no write.
    req_valid = 1'b1; req_we = 1'b1; req_re = 1'b0; req_size = 2'd2;
    req_addr = 32'hC; req_wdata = 32'hDEADBEEF; req_branch = 1'b0; req_zero = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("midbusy stall", 32'(stall1), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midbusy rst ready", 32'(rdy1), 32'd1);
    chk("midbusy rst resp_valid", 32'(rv1), 32'd0);
    chk("midbusy rst lmd", lmd1, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_rst();
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (rv1) pulses++;
    end
    chk("midbusy no pulse", 32'(pulses), 32'd0);
    do_req("lw c after rst", 0, 1, 2'd2, 0, 32'hC, 32'h0, 32'h0, 0, 0);

    do_req("sw 0 one", 1, 0, 2'd2, 0, 32'h0, 32'h1, 32'h0, 0, 0);
    do_reset();
    do_req("lw 0 after rst", 0, 1, 2'd2, 0, 32'h0, 32'h0, 32'h0, 0, 0);
`ifdef MEM_CLEAR_ON_RESET_EN
    chk("mem cleared", lmd1, 32'h0);
`else
    chk("mem survives", lmd1, 32'h1);
`endif

    // Back-to-back requests: spacing LATENCY+1 on both instances.
    do_reset();
    req_valid = 1'b1; req_we = 1'b0; req_re = 1'b1; req_size = 2'd2; req_addr = 32'h40;
    prev1 = -1; prev3 = -1; n1 = 0; n3 = 0; st3 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (stall3) st3++;
      if (rv3) begin
        n3++;
        if (prev3 < 0) chk("lat3 first resp", 32'(k), 32'd4);
        else chk("lat3 spacing", 32'(k - prev3), 32'd4);
        prev3 = k;
      end
      if (rv1) begin
        n1++;
        if (prev1 < 0) chk("lat1 first resp", 32'(k), 32'd2);
        else chk("lat1 spacing", 32'(k - prev1), 32'd2);
        prev1 = k;
      end
    end
    req_valid = 1'b0;
    chk("lat3 pulse count", 32'(n3), 32'd5);
    chk("lat1 pulse count", 32'(n1), 32'd10);
    chk("lat3 stall count", 32'(st3), 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
